uart_link: RTL and testbench

UART_LINK -- requirements
Module: uart_link

---
 rtl/uart_link.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_link.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_link.sv
// uart_link: FIFO-buffered full-duplex UART, frame = start, DATA_BITS LSB-first, stop.
// Define UART_LINK_PARITY_EN to add an even-parity bit that is sent and checked.
module uart_link #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic                 UART_TX,
  input  logic [DATA_BITS-1:0] in,
  input  logic                 send_flag,
  output logic                 tx_full,
  output logic [DATA_BITS-1:0] out,
  output logic                 rx_valid,
  input  logic                 receive_flag,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err,
  input  logic                 err_clear
);
  localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(DIV + 1);
  localparam int BW   = $clog2(DATA_BITS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

`ifdef UART_LINK_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wr, tx_rd;
  logic [AW:0]          tx_cnt;
  logic                 tx_push, tx_pop, tx_empty;

  assign tx_full  = tx_cnt == (AW+1)'(FIFO_DEPTH);
  assign tx_empty = tx_cnt == '0;
  assign tx_push  = send_flag && !tx_full;

  always_ff @(posedge CLOCK_50) begin
    if (tx_push) tx_mem[tx_wr] <= in;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end
  end

  // TX FSM: the head word stays queued through START and is popped when DATA begins
  logic [2:0]           tx_state;
  logic [CW-1:0]        tx_baud;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par, tx_line, tx_tick;

  assign tx_tick = tx_baud == CW'(DIV - 1);
  assign tx_pop  = (tx_state == S_START) && tx_tick;

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = tx_shift[0];
      S_PARITY: tx_line = tx_par;
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (tx_pop) begin
      tx_shift <= tx_mem[tx_rd];
      tx_par   <= ^tx_mem[tx_rd];
    end else if (tx_state == S_DATA && tx_tick) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      UART_TX  <= 1'b1;
    end else begin
      UART_TX <= tx_line;
      tx_baud <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_baud + CW'(1);
      case (tx_state)
        S_IDLE:   if (!tx_empty) tx_state <= S_START;
        S_START:  if (tx_tick) begin
                    tx_state <= S_DATA;
                    tx_bit   <= '0;
                  end
        S_DATA:   if (tx_tick) begin
                    tx_bit <= tx_bit + BW'(1);
                    if (tx_bit == BW'(DATA_BITS - 1)) tx_state <= PAR_EN ? S_PARITY : S_STOP;
                  end
        S_PARITY: if (tx_tick) tx_state <= S_STOP;
        S_STOP:   if (tx_tick) tx_state <= tx_empty ? S_IDLE : S_START;
        default:  tx_state <= S_IDLE;
      endcase
    end
  end

  // RX synchroniser; rx_p2 is the previous synchronised value for edge detection
  logic rx_p0, rx_p1, rx_p2;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= UART_RX;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // RX FSM: rx_hold marks a bad stop bit, waiting in STOP for the line to go high
  logic [2:0]           rx_state;
  logic [CW-1:0]        rx_baud;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_hold, rx_par_bad, rx_tick, rx_half, rx_stop_smp;
  logic                 rx_push, rx_frm_set;

  assign rx_tick     = rx_baud == CW'(DIV - 1);
  assign rx_half     = rx_baud == CW'(HALF - 1);
  assign rx_stop_smp = (rx_state == S_STOP) && !rx_hold && rx_tick;
  assign rx_push     = rx_stop_smp && rx_p1 && !rx_par_bad;
  assign rx_frm_set  = rx_stop_smp && !rx_p1;

  always_ff @(posedge CLOCK_50) begin
    if (rx_state == S_DATA && rx_tick) rx_shift <= {rx_p1, rx_shift[DATA_BITS-1:1]};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rx_state   <= S_IDLE;
      rx_baud    <= '0;
      rx_bit     <= '0;
      rx_hold    <= 1'b0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_baud <= (rx_state == S_IDLE || rx_hold || rx_tick ||
                  (rx_state == S_START && rx_half)) ? '0 : rx_baud + CW'(1);
      case (rx_state)
        S_IDLE:   if (rx_p2 && !rx_p1) begin
                    rx_state   <= S_START;
                    rx_par_bad <= 1'b0;
                  end
        S_START:  if (rx_half) begin
                    rx_state <= rx_p1 ? S_IDLE : S_DATA;
                    rx_bit   <= '0;
                  end
        S_DATA:   if (rx_tick) begin
                    rx_bit <= rx_bit + BW'(1);
                    if (rx_bit == BW'(DATA_BITS - 1)) rx_state <= PAR_EN ? S_PARITY : S_STOP;
                  end
        S_PARITY: if (rx_tick) begin
                    rx_par_bad <= rx_p1 ^ (^rx_shift);
                    rx_state   <= S_STOP;
                  end
        S_STOP:   if (rx_hold) begin
                    if (rx_p1) begin
                      rx_hold  <= 1'b0;
                      rx_state <= S_IDLE;
                    end
                  end else if (rx_tick) begin
                    if (rx_p1) rx_state <= S_IDLE;
                    else       rx_hold  <= 1'b1;
                  end
        default:  rx_state <= S_IDLE;
      endcase
    end
  end

  // RX FIFO, show-ahead output forced to 0 when empty
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        rx_wr, rx_rd;
  logic [AW:0]          rx_cnt;
  logic                 rx_full, rx_empty, rx_wr_en, rx_rd_en;

  assign rx_full  = rx_cnt == (AW+1)'(FIFO_DEPTH);
  assign rx_empty = rx_cnt == '0;
  assign rx_wr_en = rx_push && !rx_full;
  assign rx_rd_en = receive_flag && !rx_empty;
  assign rx_valid = !rx_empty;
  assign out      = rx_empty ? '0 : rx_mem[rx_rd];

  always_ff @(posedge CLOCK_50) begin
    if (rx_wr_en) rx_mem[rx_wr] <= rx_shift;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_wr_en) rx_wr <= rx_wr + AW'(1);
      if (rx_rd_en) rx_rd <= rx_rd + AW'(1);
      rx_cnt <= rx_cnt + (AW+1)'(rx_wr_en) - (AW+1)'(rx_rd_en);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || err_clear) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rx_frm_set)         frame_err <= 1'b1;
      if (rx_push && rx_full) overrun   <= 1'b1;
    end
  end

`ifdef UART_LINK_PARITY_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset || err_clear)               parity_err <= 1'b0;
    else if (rx_stop_smp && rx_p1 && rx_par_bad) parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link at DIV=10, FIFO_DEPTH=4, DATA_BITS=8.
module tb_uart_link;
  localparam int DW  = 8;
  localparam int DIV = 10;
`ifdef UART_LINK_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = DW + 2 + PB;
  localparam int FLEN  = NBITS * DIV;

  logic          clk = 1'b0, rst = 1'b1, drv_rx = 1'b1, loopback = 1'b0;
  logic          send = 1'b0, recv = 1'b0, eclr = 1'b0;
  logic [DW-1:0] din = '0;
  logic          tx, tx_full, rx_valid, ferr, ovr, perr;
  logic [DW-1:0] dout;
  int            n_chk = 0, n_err = 0;

  uart_link #(.CLK_HZ(50000000), .BAUD(5000000), .DATA_BITS(DW), .FIFO_DEPTH(4)) dut (
    .CLOCK_50(clk), .reset(rst), .UART_RX(loopback ? tx : drv_rx), .UART_TX(tx),
    .in(din), .send_flag(send), .tx_full(tx_full), .out(dout), .rx_valid(rx_valid),
    .receive_flag(recv), .frame_err(ferr), .overrun(ovr), .parity_err(perr),
    .err_clear(eclr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic fbit(input logic [DW-1:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= DW) return b[p-1];
    if (PB == 1 && p == DW + 1) return ^b;
    return 1'b1;
  endfunction

  task automatic push(input logic [DW-1:0] b);
    din = b; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic pop();
    recv = 1'b1;
    @(negedge clk);
    recv = 1'b0;
  endtask

  task automatic clr();
    eclr = 1'b1;
    @(negedge clk);
    eclr = 1'b0;
  endtask

  task automatic rx_frame(input logic [DW-1:0] b, input logic stop, input logic par_flip);
    for (int p = 0; p < NBITS; p++) begin
      drv_rx = fbit(b, p);
      if (p == NBITS - 1) drv_rx = stop;
      if (PB == 1 && p == DW + 1) drv_rx = fbit(b, p) ^ par_flip;
      repeat (DIV) @(negedge clk);
    end
    drv_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] frm [4];
    logic [DW-1:0] exp_b [4];
    int lows, k;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", tx, 1);
    chk("rst_out", dout, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_frame_err", ferr, 0);
    chk("rst_overrun", ovr, 0);
    chk("rst_parity_err", perr, 0);
    repeat (3) @(negedge clk);

    // Single frame: line falls 2 cycles after push, each bit exactly DIV wide
    push(8'hA5);
    chk("a5_tx_e0", tx, 1);
    @(negedge clk);
    chk("a5_tx_e1", tx, 1);
    @(negedge clk);
    for (int p = 0; p < NBITS; p++)
      for (int c = 0; c < DIV; c++) begin
        if (c == 0) chk($sformatf("a5_bit%0d_first", p), tx, fbit(8'hA5, p));
        if (c == DIV - 1) chk($sformatf("a5_bit%0d_last", p), tx, fbit(8'hA5, p));
        @(negedge clk);
      end
    chk("a5_idle_after", tx, 1);
    repeat (5) @(negedge clk);

    // Fill the TX FIFO: fifth word dropped, four frames sent back-to-back
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    for (int i = 0; i < 4; i++) push(exp_b[i]);
    chk("fill_tx_full_4", tx_full, 1);
    push(8'h55);
    chk("fill_tx_full_5", tx_full, 1);
    for (int f = 0; f < 4; f++) frm[f] = '0;
    for (int t = 2; t < 4 * FLEN; t++) begin
      int f, r, p, c;
      f = t / FLEN; r = t % FLEN; p = r / DIV; c = r % DIV;
      if (r == 0) chk($sformatf("b2b_start_edge%0d", f), tx, 0);
      if (r == FLEN - 1) chk($sformatf("b2b_stop_end%0d", f), tx, 1);
      if (c == 5 && p >= 1 && p <= DW) frm[f][p-1] = tx;
      @(negedge clk);
    end
    for (int f = 0; f < 4; f++) chk($sformatf("b2b_byte%0d", f), frm[f], exp_b[f]);
    lows = 0;
    for (int i = 0; i < 2 * FLEN; i++) begin
      if (tx == 1'b0) lows++;
      @(negedge clk);
    end
    chk("no_fifth_frame", lows, 0);
    chk("drained_tx_full", tx_full, 0);

    // Loopback
    loopback = 1'b1;
    push(8'h3C);
    k = 0;
    while (!rx_valid && k < 3 * FLEN) begin
      @(negedge clk);
      k++;
    end
    chk("lb_rx_valid", rx_valid, 1);
    chk("lb_out", dout, 8'h3C);
    pop();
    chk("lb_pop_valid", rx_valid, 0);
    chk("lb_pop_out", dout, 0);
    repeat (2 * FLEN) @(negedge clk);
    loopback = 1'b0;
    repeat (5) @(negedge clk);

    // RX overrun
    for (int i = 1; i <= 5; i++) rx_frame(DW'(i), 1'b1, 1'b0);
    chk("ovr_flag", ovr, 1);
    chk("ovr_rx_valid", rx_valid, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_word%0d", i), dout, i);
      pop();
    end
    chk("ovr_drained", rx_valid, 0);
    chk("ovr_out_zero", dout, 0);
    chk("ovr_no_ferr", ferr, 0);
    clr();
    chk("ovr_cleared", ovr, 0);

    // Framing error, glitch rejection, recovery
    rx_frame(8'h5A, 1'b0, 1'b0);
    chk("ferr_flag", ferr, 1);
    chk("ferr_no_push", rx_valid, 0);
    clr();
    chk("ferr_cleared", ferr, 0);
    drv_rx = 1'b0;
    repeat (3) @(negedge clk);
    drv_rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    chk("glitch_no_push", rx_valid, 0);
    chk("glitch_no_ferr", ferr, 0);
    chk("glitch_no_ovr", ovr, 0);
    rx_frame(8'h96, 1'b1, 1'b0);
    chk("recover_valid", rx_valid, 1);
    chk("recover_out", dout, 8'h96);
    pop();

`ifdef UART_LINK_PARITY_EN
    rx_frame(8'h77, 1'b1, 1'b1);
    chk("par_err_flag", perr, 1);
    chk("par_err_no_push", rx_valid, 0);
    clr();
    chk("par_err_cleared", perr, 0);
    rx_frame(8'h77, 1'b1, 1'b0);
    chk("par_ok_out", dout, 8'h77);
    chk("par_ok_flag", perr, 0);
    pop();
`else
    chk("parity_err_const", perr, 0);
`endif

    // Reset mid-TX-frame with two words still queued
    push(8'hA1); push(8'hB2); push(8'hC3);
    repeat (3 * DIV) @(negedge clk);
    chk("pre_rst_tx_active", tx_full, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx", tx, 1);
    chk("midrst_tx_full", tx_full, 0);
    lows = 0;
    for (int i = 0; i < 3 * FLEN; i++) begin
      if (tx == 1'b0) lows++;
      @(negedge clk);
    end
    chk("midrst_no_frames", lows, 0);
    chk("midrst_rx_valid", rx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
